uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. Captures every received byte (rxnew pulse plus rxdata) into a circular FIFO so back-to-back bytes at high baud rates are not lost while the CPU is busy. Exposes a polled MMIO register window in the same bus style as the UART, with byte data on d[31:24] and spo[31:24]. Provides a level interrupt.

Parameters:
DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 bytes; legal range 1..7 so count fits in 8 bits.
IRQ_THRESHOLD, 1, irq asserts when count >= this value; legal range 1..2**DEPTH_LOG2.

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
rxnew  input  1  one-cycle pulse from the UART receiver, "byte complete"
rxdata  input  8  received byte; valid in the cycle rxnew is high
a  input  3  register word address
d  input  32  write data; payload in d[31:24]
we  input  1  write strobe, one cycle per access
spo  output  32  combinational read data; payload in spo[31:24]
irq  output  1  registered level interrupt

Behaviour:
- Storage: 2**DEPTH_LOG2 x 8 register array; wr_ptr and rd_ptr of DEPTH_LOG2 bits, wrapping naturally; count of DEPTH_LOG2+1 bits. full = (count == DEPTH); empty = (count == 0).
- Reset: pointers 0, count 0, overflow 0, irq_en 0, irq 0. Array contents are don't-care. spo reads follow from this state, e.g. addr 0 reads 0.
- Read map (combinational, no side effects):
  - 0x00: {head byte, 24'b0}; 32'b0 when empty.
  - 0x01: {7'b0, !empty, 24'b0}.
  - 0x02: {count zero-extended to 8 bits, 24'b0}.
  - 0x03: {6'b0, overflow, full, 24'b0}.
  - 0x04: {7'b0, irq_en, 24'b0}.
  - Others: 32'b0.
- Write map (we high):
  - 0x01: pop. Ignored when empty.
  - 0x03: flush. Pointers and count go to 0, overflow cleared.
  - 0x04: irq_en <= d[24].
  - Other addresses: no effect.
- Push: rxnew high and not full stores rxdata at wr_ptr, wr_ptr+1, count+1.
- Latency: a byte pushed on edge N is visible on spo (addr 0 head, addr 2 count) after edge N, i.e. cycle N+1.
- Simultaneous push and pop:
  - Non-empty, not full: both happen, count unchanged.
  - Full: pop frees a slot and push succeeds; no overflow.
  - Empty: pop ignored, push succeeds, count = 1.
- Overflow: push while full and no pop in the same cycle drops the byte. Sets sticky overflow; FIFO contents unchanged.
- Flush vs push in the same cycle: flush wins. The byte is dropped and overflow ends at 0.
- irq <= irq_en & (next count >= IRQ_THRESHOLD), registered, so it is valid one cycle after the edge that changes count. Deasserts one cycle after a pop or flush brings count below threshold.
- rst mid-stream: all state cleared on the edge. A concurrent rxnew is discarded.
- Software contract: read addr 0, then write addr 1 to consume a byte. A clear-on-read scheme is not used because spo is combinational.

Decomposition:
- Register offsets (RXF_DATA=0, RXF_AVAIL=1, RXF_COUNT=2, RXF_STAT=3, RXF_IRQEN=4) go as `defines in pCPU.vh beside the existing UART offsets.
- One sub-module is natural: sync_fifo, a generic width/depth synchronous FIFO with push, pop, flush, full, empty, count, dout. uart_rx_fifo wraps it with the register decode, overflow flag and irq logic.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on separate cycles -> addr2 = 0x03000000 and addr0 = 0x41000000; pop twice -> addr0 = 0x43000000, addr1 = 0x01000000.
- Push 16 bytes 0x00..0x0F (DEPTH_LOG2=4), then push 0xAA -> addr3 = 0x03000000 (overflow and full); drain 16 pops -> sequence 0x00..0x0F with 0xAA absent, then addr0 = 0.
- Fill to full, then rxnew=0x55 and pop in the same cycle -> count stays 16, overflow 0, 0x55 is the last byte out.
- Empty FIFO, push 0x99 and pop in the same cycle -> count 1, head 0x99.
- IRQ_THRESHOLD=4, write addr4 d=0x01000000, push 3 bytes -> irq 0; 4th push -> irq 1 the next cycle; one pop -> irq 0 the next cycle.
- Flush (write addr3) coincident with rxnew=0x77 after an overflow -> count 0, addr3 = 0, irq 0; assert rst mid-burst -> all registers at reset values the next cycle.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: register word offsets and the
// byte-lane packing helper used by the read mux.
package uart_rx_fifo_pkg;

  localparam logic [2:0] RXF_DATA  = 3'd0;
  localparam logic [2:0] RXF_AVAIL = 3'd1;
  localparam logic [2:0] RXF_COUNT = 3'd2;
  localparam logic [2:0] RXF_STAT  = 3'd3;
  localparam logic [2:0] RXF_IRQEN = 3'd4;

  // The bus carries byte payloads in the top lane.
  function automatic logic [31:0] lane_hi(input logic [7:0] b);
    return {b, 24'b0};
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic synchronous circular FIFO with flush; flush overrides push and pop.
// count_next is exported so the owner can register flags off the post-edge count.
module uart_rx_fifo_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_next
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;

  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty & ~flush;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok = push & (~full | pop_ok) & ~flush;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (push_ok & ~pop_ok)
      count_next = count + (DEPTH_LOG2+1)'(1);
    else if (pop_ok & ~push_ok)
      count_next = count - (DEPTH_LOG2+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok & ~rst) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures rxnew/rxdata into a FIFO and exposes a polled
// MMIO window (payload in bits 31:24) with a sticky overflow flag and level irq.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2    = 4,
  parameter int IRQ_THRESHOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxnew,
  input  logic [7:0]  rxdata,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq
);

  logic [7:0]          head;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic [DEPTH_LOG2:0] count_next;
  logic                pop_req;
  logic                flush_req;
  logic                overflow;
  logic                irq_en;
  logic                unused_d;

  assign pop_req   = we && (a == RXF_AVAIL);
  assign flush_req = we && (a == RXF_STAT);
  assign unused_d  = ^{d[31:25], d[23:0]};

  uart_rx_fifo_sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rxnew),
    .pop        (pop_req),
    .flush      (flush_req),
    .din        (rxdata),
    .dout       (head),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .count_next (count_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      // Flush beats a coincident byte, so it also beats the overflow it would set.
      if (flush_req)
        overflow <= 1'b0;
      else if (rxnew && full && !pop_req)
        overflow <= 1'b1;
      if (we && (a == RXF_IRQEN)) irq_en <= d[24];
      irq <= irq_en && (count_next >= (DEPTH_LOG2+1)'(IRQ_THRESHOLD));
    end
  end

  always_comb begin
    spo = '0;
    case (a)
      RXF_DATA:  spo = empty ? 32'b0 : lane_hi(head);
      RXF_AVAIL: spo = lane_hi({7'b0, !empty});
      RXF_COUNT: spo = lane_hi(8'(count));
      RXF_STAT:  spo = lane_hi({6'b0, overflow, full});
      RXF_IRQEN: spo = lane_hi({7'b0, irq_en});
      default:   spo = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based model checked every cycle,
// plus literal expectations taken from worked examples.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int THR   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxnew = 1'b0;
  logic [7:0]  rxdata = 8'h00;
  logic [2:0]  a = 3'd0;
  logic [31:0] d = 32'h0;
  logic        we = 1'b0;
  logic [31:0] spo;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bit [7:0] q[$];
  bit       m_ovf = 1'b0;
  bit       m_ien = 1'b0;
  bit       m_irq = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(4), .IRQ_THRESHOLD(THR)) dut (
    .clk(clk), .rst(rst), .rxnew(rxnew), .rxdata(rxdata),
    .a(a), .d(d), .we(we), .spo(spo), .irq(irq)
  );

  // Model: FIFO as a queue, state advanced from the inputs seen at each edge.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_ien = 1'b0;
      m_irq = 1'b0;
    end else begin
      bit old_ien;
      old_ien = m_ien;
      if (we && a == 3'd3) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        if (we && a == 3'd1 && q.size() > 0) void'(q.pop_front());
        if (rxnew) begin
          if (q.size() < DEPTH) q.push_back(rxdata);
          else m_ovf = 1'b1;
        end
      end
      if (we && a == 3'd4) m_ien = d[24];
      m_irq = old_ien && (q.size() >= THR);
    end
  end

  function automatic logic [31:0] model_spo(input logic [2:0] ad);
    case (ad)
      3'd0: return (q.size() > 0) ? {q[0], 24'b0} : 32'b0;
      3'd1: return {7'b0, q.size() != 0, 24'b0};
      3'd2: return {8'(q.size()), 24'b0};
      3'd3: return {6'b0, m_ovf, q.size() == DEPTH, 24'b0};
      3'd4: return {7'b0, m_ien, 24'b0};
      default: return 32'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (spo !== model_spo(a)) begin
        n_bad++;
        $display("FAIL model_spo a=%0d: got %h want %h", a, spo, model_spo(a));
      end
      n_cmp++;
      if (irq !== m_irq) begin
        n_bad++;
        $display("FAIL model_irq: got %b want %b", irq, m_irq);
      end
    end
  end

  task automatic step(input logic rs, input logic rn, input logic [7:0] rd,
                      input logic [2:0] ad, input logic [31:0] dd, input logic w);
    @(posedge clk);
    #1;
    rst = rs; rxnew = rn; rxdata = rd; a = ad; d = dd; we = w;
  endtask

  task automatic push(input logic [7:0] b);
    step(1'b0, 1'b1, b, 3'd0, 32'h0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 8'h00, 3'd1, 32'h0, 1'b1);
  endtask

  task automatic peek(input logic [2:0] ad, input logic [31:0] exp, input string name);
    step(1'b0, 1'b0, 8'h00, ad, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (spo !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, spo, exp);
    end
  endtask

  task automatic peek_irq(input logic exp, input string name);
    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (irq !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, irq, exp);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 8'h00, 3'd0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 3'd0, 32'h0, 1'b0);
    chk_en = 1'b1;
    peek(3'd0, 32'h0, "reset_data");
    peek(3'd2, 32'h0, "reset_count");
    peek(3'd4, 32'h0, "reset_irqen");
    peek_irq(1'b0, "reset_irq");

    push(8'h41); push(8'h42); push(8'h43);
    peek(3'd2, 32'h0300_0000, "count3");
    peek(3'd0, 32'h4100_0000, "head41");
    peek(3'd5, 32'h0, "addr5_zero");
    peek(3'd7, 32'h0, "addr7_zero");
    pop(); pop();
    peek(3'd0, 32'h4300_0000, "head43");
    peek(3'd1, 32'h0100_0000, "avail1");
    pop();
    peek(3'd1, 32'h0, "avail0");

    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hAA);
    peek(3'd3, 32'h0300_0000, "ovf_full");
    for (int i = 0; i < 16; i++) begin
      peek(3'd0, {8'(i), 24'b0}, "drain_seq");
      pop();
    end
    peek(3'd0, 32'h0, "drained_empty");

    step(1'b0, 1'b0, 8'h00, 3'd3, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    step(1'b0, 1'b1, 8'h55, 3'd1, 32'h0, 1'b1);
    peek(3'd2, 32'h1000_0000, "full_pushpop_count");
    peek(3'd3, 32'h0100_0000, "full_pushpop_stat");
    for (int i = 0; i < 16; i++) begin
      peek(3'd0, (i == 15) ? 32'h5500_0000 : {8'(8'h11 + i), 24'b0}, "pushpop_seq");
      pop();
    end

    step(1'b0, 1'b1, 8'h99, 3'd1, 32'h0, 1'b1);
    peek(3'd2, 32'h0100_0000, "empty_pushpop_count");
    peek(3'd0, 32'h9900_0000, "empty_pushpop_head");
    pop();

    step(1'b0, 1'b0, 8'h00, 3'd4, 32'h0100_0000, 1'b1);
    peek(3'd4, 32'h0100_0000, "irqen_set");
    push(8'h01); push(8'h02); push(8'h03);
    peek_irq(1'b0, "irq_below");
    push(8'h04);
    peek_irq(1'b1, "irq_at_thr");
    pop();
    peek_irq(1'b0, "irq_after_pop");

    for (int i = 0; i < 14; i++) push(8'(8'h60 + i));
    peek(3'd3, 32'h0300_0000, "ovf_again");
    step(1'b0, 1'b1, 8'h77, 3'd3, 32'h0, 1'b1);
    peek(3'd3, 32'h0, "flush_stat");
    peek(3'd2, 32'h0, "flush_count");
    peek_irq(1'b0, "flush_irq");

    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4); push(8'hA5);
    step(1'b1, 1'b1, 8'hA6, 3'd0, 32'h0, 1'b0);
    peek(3'd0, 32'h0, "rst_data");
    peek(3'd2, 32'h0, "rst_count");
    peek(3'd3, 32'h0, "rst_stat");
    peek(3'd4, 32'h0, "rst_irqen");
    peek_irq(1'b0, "rst_irq");

    step(1'b0, 1'b0, 8'h00, 3'd0, 32'h0, 1'b0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
